note_highlight_renderer: RTL

NOTE_HIGHLIGHT_RENDERER -- requirements
Module: note_highlight_renderer

---
 rtl/note_highlight_renderer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/note_highlight_renderer.sv
// rtl/note_highlight_renderer.sv - piano-key note highlight dots overlaid on a video pixel stream
// Optional macro NOTE_HIGHLIGHT_FADE_EN: dim the dot to half blue during the second half of its hold.
module note_highlight_renderer #(
    parameter int NUM_VOICES  = 4,
    parameter int RADIUS      = 15,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       play_en,
    input  logic       note_valid,
    input  logic [4:0] note,
    input  logic       frame_start,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [7:0] bg_r,
    input  logic [7:0] bg_g,
    input  logic [7:0] bg_b,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [3:0] active_count
);
    localparam int          PW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic [20:0] RAD_SQ    = 21'(RADIUS * RADIUS);

    logic [NUM_VOICES-1:0] valid_q;
    logic [3:0]            cls_q  [NUM_VOICES];
    logic [7:0]            hold_q [NUM_VOICES];
    logic [PW-1:0]         rptr_q;

    logic [3:0]            key;
    logic                  trig;
    logic                  found_match;
    logic                  found_free;
    logic                  replace;
    logic [NUM_VOICES-1:0] sel;

    assign key  = 4'(note % 5'd12);
    assign trig = play_en && note_valid;

    // Priority: existing voice of the same key, else lowest free voice, else the replace pointer.
    always_comb begin
        sel         = '0;
        found_match = 1'b0;
        found_free  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (valid_q[i] && cls_q[i] == key && !found_match) begin
                sel[i]      = 1'b1;
                found_match = 1'b1;
            end
        end
        if (!found_match) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!valid_q[i] && !found_free) begin
                    sel[i]     = 1'b1;
                    found_free = 1'b1;
                end
            end
            if (!found_free) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    sel[i] = (PW'(i) == rptr_q);
                end
            end
        end
        if (!trig) begin
            sel = '0;
        end
        replace = trig && !found_match && !found_free;
    end

    always_ff @(posedge clk) begin
        if (reset || init) begin
            valid_q <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                cls_q[i]  <= 4'd0;
                hold_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (sel[i]) begin
                    valid_q[i] <= 1'b1;
                    cls_q[i]   <= key;
                    hold_q[i]  <= HOLD_INIT;
                end else if (frame_start && valid_q[i]) begin
                    hold_q[i] <= hold_q[i] - 8'd1;
                    if (hold_q[i] == 8'd1) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end
            if (replace) begin
                rptr_q <= (rptr_q == PW'(NUM_VOICES - 1)) ? '0 : rptr_q + 1'b1;
            end
        end
    end

    function automatic logic covers(input logic [3:0] k, input logic [9:0] px, input logic [8:0] py);
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [20:0] d2;
        case (k)
            4'd0:    begin cx = 10'd28;  cy = 10'd176; end
            4'd1:    begin cx = 10'd55;  cy = 10'd88;  end
            4'd2:    begin cx = 10'd82;  cy = 10'd176; end
            4'd3:    begin cx = 10'd109; cy = 10'd88;  end
            4'd4:    begin cx = 10'd136; cy = 10'd176; end
            4'd5:    begin cx = 10'd190; cy = 10'd176; end
            4'd6:    begin cx = 10'd217; cy = 10'd88;  end
            4'd7:    begin cx = 10'd244; cy = 10'd176; end
            4'd8:    begin cx = 10'd271; cy = 10'd88;  end
            4'd9:    begin cx = 10'd298; cy = 10'd176; end
            4'd10:   begin cx = 10'd325; cy = 10'd88;  end
            4'd11:   begin cx = 10'd352; cy = 10'd176; end
            default: begin cx = 10'd0;   cy = 10'd0;   end
        endcase
        dx = (px >= cx) ? px - cx : cx - px;
        dy = ({1'b0, py} >= cy) ? {1'b0, py} - cy : cy - {1'b0, py};
        d2 = 21'(20'(dx) * 20'(dx)) + 21'(20'(dy) * 20'(dy));
        return (px < 10'd382) && (py < 9'd231) && (d2 <= RAD_SQ);
    endfunction

    logic       hit;
    logic [7:0] blue;

    // Lowest-index covering voice decides the blue level.
    always_comb begin
        hit  = 1'b0;
        blue = 8'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit && valid_q[i] && covers(cls_q[i], x, y)) begin
                hit = 1'b1;
`ifdef NOTE_HIGHLIGHT_FADE_EN
                blue = (hold_q[i] > 8'(HOLD_FRAMES / 2)) ? 8'd255 : 8'd128;
`else
                blue = 8'd255;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= 8'd0;
            g <= 8'd0;
            b <= 8'd0;
        end else if (hit) begin
            r <= 8'd0;
            g <= 8'd0;
            b <= blue;
        end else begin
            r <= bg_r;
            g <= bg_g;
            b <= bg_b;
        end
    end

    always_comb begin
        active_count = 4'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_count = active_count + {3'd0, valid_q[i]};
        end
    end
endmodule
